// File: rtl/cla_serial_sub.sv
// rtl/cla_serial_sub.sv - digit-serial subtractor, one 4-bit lookahead slice per clock, LSB nibble first
// Optional signed-overflow output is built only when SUB_OVF_EN is defined.
module cla_serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int MSB = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Shared 4-bit lookahead slice, fed by the nibble selected by cnt_q.
    logic [CW+1:0] idx;
    logic [3:0]    sl_a, sl_b, sl_p, sl_g, sl_sum;
    logic          sl_cin, sl_c1, sl_c2, sl_c3, sl_c4;

    always_comb begin
        idx    = {cnt_q, 2'b00};
        sl_a   = a_q[idx +: 4];
        sl_b   = nb_q[idx +: 4];
        sl_cin = carry_q;
        sl_p   = sl_a ^ sl_b;
        sl_g   = sl_a & sl_b;
        sl_c1  = sl_g[0] | (sl_p[0] & sl_cin);
        sl_c2  = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & sl_cin);
        sl_c3  = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
               | (sl_p[2] & sl_p[1] & sl_p[0] & sl_cin);
        sl_c4  = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
               | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
               | (&sl_p & sl_cin);
        sl_sum = sl_p ^ {sl_c3, sl_c2, sl_c1, sl_cin};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        nb_d     = nb_q;
        work_d   = work_q;
        diff_d   = diff_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
`ifdef SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    nb_d    = ~b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                work_d[idx +: 4] = sl_sum;
                carry_d          = sl_c4;
                cnt_d            = cnt_q + CW'(1);
                // Result registers load on entry to DONE so they are valid while done is high.
                if (cnt_q == LAST) begin
                    cnt_d    = '0;
                    diff_d   = work_d;
                    borrow_d = ~sl_c4;
`ifdef SUB_OVF_EN
                    // b's sign is ~nb_q[MSB], so "signs differ" reduces to a_q[MSB] == nb_q[MSB].
                    ovf_d    = ~(a_q[MSB] ^ nb_q[MSB]) & (work_d[MSB] ^ a_q[MSB]);
`endif
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            nb_q     <= '0;
            work_q   <= '0;
            diff_q   <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            nb_q     <= nb_d;
            work_q   <= work_d;
            diff_q   <= diff_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_cla_serial_sub.sv
// tb/tb_cla_serial_sub.sv - scoreboard bench for cla_serial_sub (WIDTH=16, SUB_OVF_EN optional)
module tb_cla_serial_sub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow, ovf_s;
    logic [W-1:0] diff;

    typedef struct packed {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

`ifdef SUB_OVF_EN
    logic ovf;
    assign ovf_s = ovf;
    cla_serial_sub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ovf(ovf)
    );
`else
    assign ovf_s = 1'b0;
    cla_serial_sub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow)
    );
`endif

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.d  = x - y;
        e.br = (x < y);
`ifdef SUB_OVF_EN
        e.ov = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
`else
        e.ov = 1'b0;
`endif
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        sb_q.push_back(model(x, y));
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    // Called on the negedge after the accepting edge; returns edges-to-done and busy cycles seen.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat = 1;
        busy_cyc = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        if (busy) busy_cyc++;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
        total_cnt++;
        if (diff !== '0) $display("FAIL reset_diff got=%h exp=0000", diff); else pass_cnt++;
        total_cnt++;
        if ({borrow, ovf_s} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {borrow, ovf_s}); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_vectors;
        logic [W-1:0] va[5] = '{16'h1234, 16'h0000, 16'h1000, 16'h8000, 16'h7FFF};
        logic [W-1:0] vb[5] = '{16'h0034, 16'h0001, 16'h0001, 16'h0001, 16'hFFFF};
        int lat, bc;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(va[i], vb[i]);
            wait_done(lat, bc);
            total_cnt++;
            if (lat !== 5) $display("FAIL vec%0d_latency got=%0d exp=5", i, lat); else pass_cnt++;
            total_cnt++;
            if (bc !== 5) $display("FAIL vec%0d_busy_cycles got=%0d exp=5", i, bc); else pass_cnt++;
            e = sb_q.pop_front();
            total_cnt++;
            if ({diff, borrow, ovf_s} !== {e.d, e.br, e.ov})
                $display("FAIL vec%0d_result got=%h/%b/%b exp=%h/%b/%b", i, diff, borrow, ovf_s, e.d, e.br, e.ov);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if ({done, busy} !== 2'b00) $display("FAIL vec%0d_after_done got=%b exp=00", i, {done, busy}); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        int n_done = 0;
        int first = -1;
        int second = -1;
        exp_t e;
        @(negedge clk);
        a = 16'h0005;
        b = 16'h0003;
        start = 1'b1;
        sb_q.push_back(model(16'h0005, 16'h0003));
        sb_q.push_back(model(16'h0005, 16'h0003));
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (i == 12) start = 1'b0;
            if (done) begin
                n_done++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    total_cnt++;
                    if ({diff, borrow, ovf_s} !== {e.d, e.br, e.ov})
                        $display("FAIL b2b_result got=%h/%b/%b exp=%h/%b/%b", diff, borrow, ovf_s, e.d, e.br, e.ov);
                    else pass_cnt++;
                end
            end
        end
        total_cnt++;
        if (n_done !== 2) $display("FAIL b2b_op_count got=%0d exp=2", n_done); else pass_cnt++;
        total_cnt++;
        if (second - first !== 6) $display("FAIL b2b_done_spacing got=%0d exp=6", second - first); else pass_cnt++;
        sb_q.delete();
    endtask

    task automatic test_reset_mid_run;
        int lat, bc;
        int seen = 0;
        exp_t e;
        issue(16'h1234, 16'h0034);
        wait_done(lat, bc);
        e = sb_q.pop_front();
        total_cnt++;
        if ({diff, borrow} !== {e.d, e.br}) $display("FAIL pre_reset_result got=%h exp=%h", diff, e.d); else pass_cnt++;
        @(negedge clk);
        issue(16'h4321, 16'h0001);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL midrun_reset_busy got=%b exp=00", {busy, done}); else pass_cnt++;
        total_cnt++;
        if (diff !== '0) $display("FAIL midrun_reset_diff got=%h exp=0000", diff); else pass_cnt++;
        void'(sb_q.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL midrun_dropped_done got=%0d exp=0", seen); else pass_cnt++;
        issue(16'h0F0F, 16'h0101);
        wait_done(lat, bc);
        e = sb_q.pop_front();
        total_cnt++;
        if ({diff, borrow, ovf_s} !== {e.d, e.br, e.ov})
            $display("FAIL post_reset_result got=%h/%b/%b exp=%h/%b/%b", diff, borrow, ovf_s, e.d, e.br, e.ov);
        else pass_cnt++;
    endtask

    task automatic test_random;
        int lat, bc;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            issue(W'($urandom), W'($urandom));
            wait_done(lat, bc);
            e = sb_q.pop_front();
            total_cnt++;
            if (!done || {diff, borrow, ovf_s} !== {e.d, e.br, e.ov})
                $display("FAIL rand%0d_result done=%b got=%h/%b/%b exp=%h/%b/%b", i, done, diff, borrow, ovf_s, e.d, e.br, e.ov);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
